vfu_result_wb_arbiter: RTL and testbench
========================================

# vfu_result_wb_arbiter

Per-lane write-back stage directly downstream of the vector functional-units stage. It arbitrates the ALU and MFPU result write requests onto the single lane VRF write port, holds the winning request in a one-entry output register, and returns grants to the functional units. It also exports a per-instruction pending-write vector so the lane sequencer can see writes still in flight.

## Interface
Parameters:
- NrLanes, 0, number of lanes. Informational only; kept for instantiation symmetry.
- vaddr_t, logic, VRF element address type.
- DataWidth, $bits(elen_t), localparam.
- strb_t, logic [DataWidth/8-1:0], localparam byte-enable type.

Ports:
- clk_i  in  1  clock; one clock domain.
- rst_ni  in  1  reset; synchronous, active-low.
- alu_result_req_i  in  1  ALU write request.
- alu_result_id_i  in  vid_t  ALU instruction ID.
- alu_result_addr_i  in  vaddr_t  ALU write address.
- alu_result_wdata_i  in  elen_t  ALU write data.
- alu_result_be_i  in  strb_t  ALU byte enables.
- alu_result_gnt_o  out  1  ALU request accepted this cycle.
- mfpu_result_req_i / _id_i / _addr_i / _wdata_i / _be_i  in  same widths as the ALU ports  MFPU write request.
- mfpu_result_gnt_o  out  1  MFPU request accepted this cycle.
- vrf_wr_req_o  out  1  output register valid.
- vrf_wr_id_o  out  vid_t  registered ID.
- vrf_wr_addr_o  out  vaddr_t  registered address.
- vrf_wr_wdata_o  out  elen_t  registered data.
- vrf_wr_be_o  out  strb_t  registered byte enables.
- vrf_wr_gnt_i  in  1  VRF accepted the registered write.
- wb_pending_o  out  NrVInsn  bit v is high while the output register holds a write with ID v.

## Operation
- State:
  - output register: valid_q plus a payload of id, addr, wdata, be.
  - round-robin pointer rr_q: 0 means ALU has priority, 1 means MFPU has priority.
- Load enable: load = !valid_q | vrf_wr_gnt_i.
- Arbitration is combinational and happens only when load is high:
  - Only one requester: that requester wins.
  - Both request: rr_q selects the winner.
  - Neither requests: no winner.
- Grant:
  - The winner's gnt_o is asserted in the same cycle. Grants are never asserted when load is low.
  - At most one gnt_o is high per cycle.
- Register update on a cycle where load is high:
  - valid_q <= (winner exists).
  - Payload <= winner's fields. The payload is don't-care when there is no winner.
- rr_q update:
  - On any grant, rr_q <= (winner == ALU), so the other unit has priority next.
  - rr_q is unchanged when there is no grant.
- The payload stays stable while valid_q & !vrf_wr_gnt_i.
- vrf_wr_gnt_i while valid_q is low is ignored.
- Requesters may drop or change a request without having been granted. The block keeps no memory of ungranted requests.
- wb_pending_o = valid_q ? (1 << id_q) : '0.
- The block never modifies, merges or reorders the data or byte enables of a single write.
- Reset (synchronous, rst_ni low at a clock edge):
  - valid_q=0, rr_q=0, payload=0.
  - A write held in the output register at that edge is dropped.
- Reset values of outputs: vrf_wr_req_o=0, vrf_wr_id_o=0, vrf_wr_addr_o=0, vrf_wr_wdata_o=0, vrf_wr_be_o=0, wb_pending_o=0. Both gnt_o are 0 while rst_ni is low.

## Timing
- Latency: a request granted in cycle N appears on vrf_wr_* in cycle N+1.
- Throughput: one write per cycle when the VRF grants continuously. Back-to-back grants are allowed in the same cycle as a drain (full-throughput pipeline).
- Output register full and no vrf_wr_gnt_i: both gnt_o are 0. Requests are back-pressured with no loss.
- Output register full and vrf_wr_gnt_i: the current write drains and a new winner loads in the same edge. wb_pending_o switches to the new ID in the next cycle.
- Both units requesting continuously with the VRF always granting: strict ALU/MFPU alternation starting from rr_q.
- All outputs except gnt_o come from registers. The gnt_o path is combinational from the *_req_i inputs and vrf_wr_gnt_i.

## Structure
- Use the shared definitions of vid_t, elen_t and NrVInsn in ara_pkg. Add no new package types.
- No sub-module: arbitration and the output register are implemented inline, about 150 lines.
- Instantiated once per lane, beside vector_fus_stage, between its result ports and the VRF write arbiter.

## Test plan
- Reset, then ALU req with addr=0x10, wdata=0xDEAD_BEEF, be=0xFF, id=2 -> alu_result_gnt_o=1 in cycle 0. Cycle 1: vrf_wr_req_o=1 with the same fields, and wb_pending_o=0b0000_0100.
- ALU and MFPU requesting together for 4 cycles, vrf_wr_gnt_i=1 -> grants ALU, MFPU, ALU, MFPU. rr_q ends at 0.
- Register full, vrf_wr_gnt_i=0 for 3 cycles while both request -> no gnt_o, and vrf_wr_* stays constant. Raise vrf_wr_gnt_i -> the same-cycle reload goes to the rr_q winner.
- vrf_wr_gnt_i=1 with no valid write and no requests -> outputs stay 0 and rr_q is unchanged.
- MFPU write with id=5 held stalled, then rst_ni=0 for 1 cycle -> the next cycle shows vrf_wr_req_o=0, wb_pending_o=0 and rr_q=0. The first post-reset contested grant goes to ALU.
- Random requests and gnt for 10k cycles -> the scoreboard sees every granted write exactly once, in grant order, with no duplicates or losses, and never both gnt_o high at once.

Source files
------------

// File: rtl/ara_pkg.sv
// Shared vector-unit definitions used across the lane datapath.
package ara_pkg;

  localparam int unsigned NrVInsn = 8;
  localparam int unsigned ELEN    = 64;

  typedef logic [$clog2(NrVInsn)-1:0] vid_t;
  typedef logic [ELEN-1:0]            elen_t;

endpackage

// File: rtl/vfu_result_wb_arbiter.sv
// Per-lane result write-back: round-robin ALU/MFPU arbitration into a one-entry
// output register that feeds the lane VRF write port.
module vfu_result_wb_arbiter
  import ara_pkg::*;
#(
  parameter int unsigned NrLanes   = 0,
  parameter type         vaddr_t   = logic,
  localparam int unsigned DataWidth = $bits(elen_t),
  localparam type        strb_t    = logic [DataWidth/8-1:0]
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               alu_result_req_i,
  input  vid_t               alu_result_id_i,
  input  vaddr_t             alu_result_addr_i,
  input  elen_t              alu_result_wdata_i,
  input  strb_t              alu_result_be_i,
  output logic               alu_result_gnt_o,
  input  logic               mfpu_result_req_i,
  input  vid_t               mfpu_result_id_i,
  input  vaddr_t             mfpu_result_addr_i,
  input  elen_t              mfpu_result_wdata_i,
  input  strb_t              mfpu_result_be_i,
  output logic               mfpu_result_gnt_o,
  output logic               vrf_wr_req_o,
  output vid_t               vrf_wr_id_o,
  output vaddr_t             vrf_wr_addr_o,
  output elen_t              vrf_wr_wdata_o,
  output strb_t              vrf_wr_be_o,
  input  logic               vrf_wr_gnt_i,
  output logic [NrVInsn-1:0] wb_pending_o
);

  if (NrLanes > 1024) begin : gen_nr_lanes_check
    $error("NrLanes out of range");
  end

  logic   valid_q;
  logic   rr_q;
  vid_t   id_q;
  vaddr_t addr_q;
  elen_t  wdata_q;
  strb_t  be_q;

  logic load;
  logic pick_alu, pick_mfpu;
  logic any_gnt;

  // The register may refill on the same edge that the VRF drains it.
  assign load = !valid_q || vrf_wr_gnt_i;

  // rr_q == 1 hands a contested cycle to the MFPU.
  assign pick_alu  = alu_result_req_i && (!mfpu_result_req_i || !rr_q);
  assign pick_mfpu = mfpu_result_req_i && (!alu_result_req_i || rr_q);

  assign alu_result_gnt_o  = rst_ni && load && pick_alu;
  assign mfpu_result_gnt_o = rst_ni && load && pick_mfpu;
  assign any_gnt           = alu_result_gnt_o || mfpu_result_gnt_o;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      valid_q <= 1'b0;
      rr_q    <= 1'b0;
      id_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
    end else if (load) begin
      valid_q <= any_gnt;
      if (alu_result_gnt_o) begin
        id_q    <= alu_result_id_i;
        addr_q  <= alu_result_addr_i;
        wdata_q <= alu_result_wdata_i;
        be_q    <= alu_result_be_i;
      end else if (mfpu_result_gnt_o) begin
        id_q    <= mfpu_result_id_i;
        addr_q  <= mfpu_result_addr_i;
        wdata_q <= mfpu_result_wdata_i;
        be_q    <= mfpu_result_be_i;
      end
      if (any_gnt) begin
        rr_q <= alu_result_gnt_o;
      end
    end
  end

  assign vrf_wr_req_o   = valid_q;
  assign vrf_wr_id_o    = id_q;
  assign vrf_wr_addr_o  = addr_q;
  assign vrf_wr_wdata_o = wdata_q;
  assign vrf_wr_be_o    = be_q;

  always_comb begin
    wb_pending_o = '0;
    if (valid_q) begin
      wb_pending_o[id_q] = 1'b1;
    end
  end

endmodule

// File: tb/tb_vfu_result_wb_arbiter.sv
// Directed and randomized checks of the ALU/MFPU write-back arbiter.
module tb_vfu_result_wb_arbiter;
  import ara_pkg::*;

  typedef logic [9:0] vaddr_t;
  typedef logic [7:0] strb_t;

  typedef struct packed {
    vid_t   id;
    vaddr_t addr;
    elen_t  data;
    strb_t  be;
  } wr_t;

  logic               clk = 1'b0;
  logic               rst_ni;
  logic               alu_req, mfpu_req, alu_gnt, mfpu_gnt;
  vid_t               alu_id, mfpu_id, wr_id;
  vaddr_t             alu_addr, mfpu_addr, wr_addr;
  elen_t              alu_data, mfpu_data, wr_data;
  strb_t              alu_be, mfpu_be, wr_be;
  logic               wr_req, wr_gnt;
  logic [NrVInsn-1:0] pending;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  vfu_result_wb_arbiter #(
    .NrLanes(4),
    .vaddr_t(vaddr_t)
  ) dut (
    .clk_i              (clk),
    .rst_ni             (rst_ni),
    .alu_result_req_i   (alu_req),
    .alu_result_id_i    (alu_id),
    .alu_result_addr_i  (alu_addr),
    .alu_result_wdata_i (alu_data),
    .alu_result_be_i    (alu_be),
    .alu_result_gnt_o   (alu_gnt),
    .mfpu_result_req_i  (mfpu_req),
    .mfpu_result_id_i   (mfpu_id),
    .mfpu_result_addr_i (mfpu_addr),
    .mfpu_result_wdata_i(mfpu_data),
    .mfpu_result_be_i   (mfpu_be),
    .mfpu_result_gnt_o  (mfpu_gnt),
    .vrf_wr_req_o       (wr_req),
    .vrf_wr_id_o        (wr_id),
    .vrf_wr_addr_o      (wr_addr),
    .vrf_wr_wdata_o     (wr_data),
    .vrf_wr_be_o        (wr_be),
    .vrf_wr_gnt_i       (wr_gnt),
    .wb_pending_o       (pending)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic alu_set(input logic r, input vid_t i, input vaddr_t a, input elen_t d,
                         input strb_t b);
    alu_req = r; alu_id = i; alu_addr = a; alu_data = d; alu_be = b;
  endtask

  task automatic mfpu_set(input logic r, input vid_t i, input vaddr_t a, input elen_t d,
                          input strb_t b);
    mfpu_req = r; mfpu_id = i; mfpu_addr = a; mfpu_data = d; mfpu_be = b;
  endtask

  task automatic chk_out(input string tag, input logic v, input wr_t w);
    chk({tag, "_req"}, wr_req, v);
    chk({tag, "_payload"}, {wr_id, wr_addr, wr_data, wr_be}, w);
    chk({tag, "_pending"}, pending, v ? (8'h01 << w.id) : 8'h00);
  endtask

  wr_t    sb[$];
  wr_t    mreg, got;
  logic   mvalid, mrr, load, ea, em;

  initial begin
    rst_ni = 1'b0;
    wr_gnt = 1'b0;
    mfpu_set(1'b0, '0, '0, '0, '0);
    alu_set(1'b1, 3'd2, 10'h10, 64'hDEAD_BEEF, 8'hFF);
    step();
    step();
    chk("rst_gnts", {alu_gnt, mfpu_gnt}, 2'b00);
    chk_out("rst", 1'b0, '0);
    chk("rst_rr", dut.rr_q, 1'b0);

    // Single ALU write.
    rst_ni = 1'b1;
    #1;
    chk("t1_gnts", {alu_gnt, mfpu_gnt}, 2'b10);
    step();
    alu_req = 1'b0;
    chk_out("t1_out", 1'b1, '{3'd2, 10'h10, 64'hDEAD_BEEF, 8'hFF});
    chk("t1_rr", dut.rr_q, 1'b1);

    wr_gnt = 1'b1;
    step();
    mfpu_set(1'b1, 3'd3, 10'h33, 64'h3333, 8'h0F);
    #1;
    chk("t2_pre_gnts", {alu_gnt, mfpu_gnt}, 2'b01);
    step();
    chk("t2_rr0", dut.rr_q, 1'b0);

    // Contested, VRF always granting: strict alternation from ALU.
    alu_set(1'b1, 3'd1, 10'h20, 64'hA1A1, 8'hF0);
    mfpu_set(1'b1, 3'd4, 10'h30, 64'hB4B4, 8'h0F);
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("t2_alt_gnts", {alu_gnt, mfpu_gnt}, (i % 2 == 0) ? 2'b10 : 2'b01);
      step();
      chk("t2_alt_id", wr_id, (i % 2 == 0) ? 3'd1 : 3'd4);
    end
    chk("t2_rr_end", dut.rr_q, 1'b0);

    // Full and stalled: back-pressure with stable payload.
    wr_gnt = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("t3_stall_gnts", {alu_gnt, mfpu_gnt}, 2'b00);
      step();
      chk_out("t3_stall_out", 1'b1, '{3'd4, 10'h30, 64'hB4B4, 8'h0F});
    end
    wr_gnt = 1'b1;
    #1;
    chk("t3_reload_gnts", {alu_gnt, mfpu_gnt}, 2'b10);
    step();
    chk_out("t3_reload_out", 1'b1, '{3'd1, 10'h20, 64'hA1A1, 8'hF0});

    // VRF grant with nothing held or requested.
    alu_req = 1'b0;
    mfpu_req = 1'b0;
    step();
    step();
    chk("t4_gnts", {alu_gnt, mfpu_gnt}, 2'b00);
    chk("t4_req", wr_req, 1'b0);
    chk("t4_pending", pending, 8'h00);
    chk("t4_rr", dut.rr_q, 1'b1);

    // Stalled MFPU write dropped by reset.
    wr_gnt = 1'b0;
    mfpu_set(1'b1, 3'd5, 10'h55, 64'h5555_AAAA, 8'h3C);
    #1;
    chk("t5_gnts", {alu_gnt, mfpu_gnt}, 2'b01);
    step();
    mfpu_req = 1'b0;
    chk_out("t5_held", 1'b1, '{3'd5, 10'h55, 64'h5555_AAAA, 8'h3C});
    step();
    chk("t5_still_held", wr_req, 1'b1);
    rst_ni = 1'b0;
    step();
    rst_ni = 1'b1;
    chk_out("t5_rst", 1'b0, '0);
    chk("t5_rst_rr", dut.rr_q, 1'b0);
    alu_req = 1'b1;
    mfpu_req = 1'b1;
    #1;
    chk("t5_post_gnts", {alu_gnt, mfpu_gnt}, 2'b10);
    step();
    chk("t5_post_id", wr_id, 3'd1);
    alu_req = 1'b0;
    mfpu_req = 1'b0;
    wr_gnt = 1'b1;
    step();

    // Random traffic against a reference model and in-order scoreboard.
    mvalid = 1'b0;
    mrr = 1'b1;
    for (int c = 0; c < 10000; c++) begin
      alu_set(($urandom_range(0, 9) < 6), vid_t'($urandom), vaddr_t'($urandom),
              {$urandom, $urandom}, strb_t'($urandom));
      mfpu_set(($urandom_range(0, 9) < 6), vid_t'($urandom), vaddr_t'($urandom),
               {$urandom, $urandom}, strb_t'($urandom));
      wr_gnt = ($urandom_range(0, 1) == 1);
      #1;
      chk("rnd_req", wr_req, mvalid);
      load = !mvalid || wr_gnt;
      ea = load && alu_req && (!mfpu_req || !mrr);
      em = load && mfpu_req && (!alu_req || mrr);
      chk("rnd_gnts", {alu_gnt, mfpu_gnt}, {ea, em});
      if (alu_gnt && mfpu_gnt) chk("rnd_onehot", 1'b1, 1'b0);
      if (wr_req && wr_gnt) begin
        if (sb.size() == 0) begin
          chk("rnd_spurious", 1'b1, 1'b0);
        end else begin
          got = sb.pop_front();
          chk("rnd_sb", {wr_id, wr_addr, wr_data, wr_be}, got);
        end
      end
      if (load) begin
        mvalid = ea || em;
        if (ea) begin
          mreg = '{alu_id, alu_addr, alu_data, alu_be};
          sb.push_back(mreg);
          mrr = 1'b1;
        end else if (em) begin
          mreg = '{mfpu_id, mfpu_addr, mfpu_data, mfpu_be};
          sb.push_back(mreg);
          mrr = 1'b0;
        end
      end
      step();
    end
    chk("rnd_sb_left", sb.size(), mvalid ? 1 : 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
